pktfifo: RTL and testbench

PKTFIFO -- requirements
Module: pktfifo

---
 rtl/pktfifo.sv | 134 +++++++++++++
 tb/tb_pktfifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pktfifo.sv
// pktfifo: packet-oriented byte FIFO between the correlator packet
// assembler and a byte-wide reader. Bytes are pushed speculatively and
// only become visible to the read side when the packet is committed. A
// packet that overflows the buffer is discarded in full at its commit,
// and the overflow is counted in o_nDropped.
//
// Ports:
//   i_clk        - sole clock, rising edge
//   i_rst        - asynchronous active-high reset
//   i_cg         - clock-gate enable; 0 holds all state
//   i_data       - byte to write
//   i_push       - write i_data this cycle
//   i_commit     - end of packet; publish all pushed bytes
//   o_full       - no space for another byte
//   o_data       - byte at read head (show-ahead)
//   o_empty      - no committed unread bytes
//   i_pop        - consume byte at read head
//   i_flush      - discard all contents
//   o_nCommitted - committed unread byte count
//   o_nDropped   - packets dropped for overflow, saturating at 255
module pktfifo #(
    parameter int DEPTH = 50,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic [7:0]       i_data,
    input  logic             i_push,
    input  logic             i_commit,
    output logic             o_full,
    output logic [7:0]       o_data,
    output logic             o_empty,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_nCommitted,
    output logic [7:0]       o_nDropped
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd, cm, wr;
    logic [CNT_W-1:0] n_used, n_comm;
    logic             dropping;
    logic [7:0]       n_dropped;

    logic [PTR_W-1:0] rd_nxt, cm_nxt, wr_nxt, wr_adv;
    logic [CNT_W-1:0] n_used_nxt, n_comm_nxt, n_used_mid, n_comm_mid;
    logic             dropping_nxt;
    logic [7:0]       n_dropped_nxt;
    logic             push_ok, push_drop, drop_now, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full       = (n_used == CNT_W'(DEPTH));
    assign o_empty      = (n_comm == '0);
    assign o_nCommitted = n_comm;
    assign o_nDropped   = n_dropped;
    assign o_data       = mem[rd];

    always_comb begin
        push_ok   = i_push && !o_full && !dropping;
        push_drop = i_push &&  o_full && !dropping;
        // A packet that overflows on the same cycle it commits is still a
        // dropped packet, so the commit sees the effective drop state.
        drop_now  = dropping || push_drop;
        pop_ok    = i_pop && !o_empty;

        wr_adv     = push_ok ? ptr_inc(wr) : wr;
        n_used_mid = n_used + CNT_W'(push_ok) - CNT_W'(pop_ok);
        n_comm_mid = n_comm - CNT_W'(pop_ok);

        rd_nxt        = pop_ok ? ptr_inc(rd) : rd;
        cm_nxt        = cm;
        wr_nxt        = wr_adv;
        n_used_nxt    = n_used_mid;
        n_comm_nxt    = n_comm_mid;
        dropping_nxt  = drop_now;
        n_dropped_nxt = n_dropped;

        if (i_commit) begin
            if (drop_now) begin
                // Roll the write side back to the last packet boundary.
                wr_nxt        = cm;
                n_used_nxt    = n_comm_mid;
                dropping_nxt  = 1'b0;
                n_dropped_nxt = (n_dropped == 8'hFF) ? n_dropped : n_dropped + 8'd1;
            end else begin
                cm_nxt     = wr_adv;
                n_comm_nxt = n_used_mid;
            end
        end

        if (i_flush) begin
            rd_nxt        = '0;
            cm_nxt        = '0;
            wr_nxt        = '0;
            n_used_nxt    = '0;
            n_comm_nxt    = '0;
            dropping_nxt  = 1'b0;
            n_dropped_nxt = n_dropped;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd        <= '0;
            cm        <= '0;
            wr        <= '0;
            n_used    <= '0;
            n_comm    <= '0;
            dropping  <= 1'b0;
            n_dropped <= '0;
        end else if (i_cg) begin
            rd        <= rd_nxt;
            cm        <= cm_nxt;
            wr        <= wr_nxt;
            n_used    <= n_used_nxt;
            n_comm    <= n_comm_nxt;
            dropping  <= dropping_nxt;
            n_dropped <= n_dropped_nxt;
        end
    end

    // Storage is not reset; unread contents are unreachable after reset.
    always_ff @(posedge i_clk) begin
        if (i_cg && push_ok && !i_flush)
            mem[wr] <= i_data;
    end

endmodule

// File: tb/tb_pktfifo.sv
// tb_pktfifo: directed self-checking bench for pktfifo (DEPTH=50).
module tb_pktfifo;

    logic       i_clk = 1'b0;
    logic       i_rst, i_cg, i_push, i_commit, i_pop, i_flush;
    logic [7:0] i_data;
    logic       o_full, o_empty;
    logic [7:0] o_data, o_nDropped;
    logic [5:0] o_nCommitted;

    int n_cmp = 0;
    int n_bad = 0;

    pktfifo #(.DEPTH(50)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_data(i_data),
        .i_push(i_push), .i_commit(i_commit), .o_full(o_full),
        .o_data(o_data), .o_empty(o_empty), .i_pop(i_pop),
        .i_flush(i_flush), .o_nCommitted(o_nCommitted), .o_nDropped(o_nDropped)
    );

    always #5 i_clk = ~i_clk;

    task automatic drive(input logic push, input logic [7:0] data,
                         input logic commit, input logic pop, input logic flush);
        i_push = push; i_data = data; i_commit = commit; i_pop = pop; i_flush = flush;
        @(posedge i_clk);
        #1;
        i_push = 0; i_commit = 0; i_pop = 0; i_flush = 0;
    endtask

    task automatic test_reset;
        i_rst = 1; i_cg = 1; i_push = 0; i_commit = 0; i_pop = 0; i_flush = 0; i_data = 0;
        #3;
        n_cmp++;
        if (o_empty !== 1'b1 || o_full !== 1'b0 || o_nCommitted !== 6'd0 || o_nDropped !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_during got empty=%b full=%b ncom=%0d ndrop=%0d want 1 0 0 0",
                     o_empty, o_full, o_nCommitted, o_nDropped);
        end
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 0;
        @(posedge i_clk); #1;
        n_cmp++;
        if (o_empty !== 1'b1 || o_full !== 1'b0 || o_nCommitted !== 6'd0 || o_nDropped !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_after got empty=%b full=%b ncom=%0d ndrop=%0d want 1 0 0 0",
                     o_empty, o_full, o_nCommitted, o_nDropped);
        end
    endtask

    task automatic test_basic;
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        drive(1, 8'h11, 0, 0, 0);
        drive(1, 8'h22, 0, 0, 0);
        drive(1, 8'h33, 1, 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd3 || o_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_commit got ncom=%0d empty=%b want 3 0", o_nCommitted, o_empty);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_data !== exp[i]) begin
                n_bad++;
                $display("FAIL basic_pop%0d got %h want %h", i, o_data, exp[i]);
            end
            drive(0, 0, 0, 1, 0);
        end
        n_cmp++;
        if (o_empty !== 1'b1 || o_nCommitted !== 6'd0) begin
            n_bad++;
            $display("FAIL basic_drained got empty=%b ncom=%0d want 1 0", o_empty, o_nCommitted);
        end
    endtask

    task automatic test_uncommitted;
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'hA0 + 8'(i), 0, 0, 0);
            n_cmp++;
            if (o_empty !== 1'b1 || o_nCommitted !== 6'd0) begin
                n_bad++;
                $display("FAIL uncommitted_hidden%0d got empty=%b ncom=%0d want 1 0", i, o_empty, o_nCommitted);
            end
        end
        // popping while nothing is committed must be ignored
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd5 || o_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL uncommitted_publish got ncom=%0d empty=%b want 5 0", o_nCommitted, o_empty);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (o_data !== 8'hA0 + 8'(i)) begin
                n_bad++;
                $display("FAIL uncommitted_pop%0d got %h want %h", i, o_data, 8'hA0 + 8'(i));
            end
            drive(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 48; i++) drive(1, 8'(i), (i == 47), 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd48) begin
            n_bad++;
            $display("FAIL ovf_base got ncom=%0d want 48", o_nCommitted);
        end
        drive(1, 8'hF1, 0, 0, 0);
        drive(1, 8'hF2, 0, 0, 0);
        n_cmp++;
        if (o_full !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_full got %b want 1", o_full);
        end
        drive(1, 8'hF3, 0, 0, 0);
        drive(1, 8'hF4, 1, 0, 0);
        n_cmp++;
        if (o_nDropped !== 8'd1 || o_nCommitted !== 6'd48 || o_full !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_drop got ndrop=%0d ncom=%0d full=%b want 1 48 0", o_nDropped, o_nCommitted, o_full);
        end
        // a fresh packet after the drop must land where the dropped one began
        drive(1, 8'hE1, 0, 0, 0);
        drive(1, 8'hE2, 1, 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd50 || o_full !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_refill got ncom=%0d full=%b want 50 1", o_nCommitted, o_full);
        end
        for (int i = 0; i < 50; i++) begin
            logic [7:0] e;
            e = (i < 48) ? 8'(i) : ((i == 48) ? 8'hE1 : 8'hE2);
            n_cmp++;
            if (o_data !== e) begin
                n_bad++;
                $display("FAIL ovf_drain%0d got %h want %h", i, o_data, e);
            end
            drive(0, 0, 0, 1, 0);
        end
        n_cmp++;
        if (o_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_empty got %b want 1", o_empty);
        end
    endtask

    task automatic test_wrap;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 30; i++) drive(1, 8'(r * 40 + i), (i == 29), 0, 0);
            n_cmp++;
            if (o_nCommitted !== 6'd30) begin
                n_bad++;
                $display("FAIL wrap_count%0d got %0d want 30", r, o_nCommitted);
            end
            for (int i = 0; i < 30; i++) begin
                n_cmp++;
                if (o_data !== 8'(r * 40 + i)) begin
                    n_bad++;
                    $display("FAIL wrap_r%0d_b%0d got %h want %h", r, i, o_data, 8'(r * 40 + i));
                end
                drive(0, 0, 0, 1, 0);
            end
        end
        n_cmp++;
        if (o_empty !== 1'b1 || o_nCommitted !== 6'd0) begin
            n_bad++;
            $display("FAIL wrap_end got empty=%b ncom=%0d want 1 0", o_empty, o_nCommitted);
        end
    endtask

    task automatic test_cg;
        i_cg = 0;
        drive(1, 8'h5A, 1, 0, 0);
        i_cg = 1;
        n_cmp++;
        if (o_nCommitted !== 6'd0 || o_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL cg_hold got ncom=%0d empty=%b want 0 1", o_nCommitted, o_empty);
        end
    endtask

    task automatic test_flush_simul;
        for (int i = 0; i < 10; i++) drive(1, 8'h30 + 8'(i), (i == 9), 0, 0);
        drive(1, 8'h77, 0, 0, 0);
        drive(1, 8'h78, 0, 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd10) begin
            n_bad++;
            $display("FAIL flush_pre got ncom=%0d want 10", o_nCommitted);
        end
        drive(1, 8'h99, 1, 1, 1);
        n_cmp++;
        if (o_nCommitted !== 6'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_nDropped !== 8'd1) begin
            n_bad++;
            $display("FAIL flush_all got ncom=%0d empty=%b full=%b ndrop=%0d want 0 1 0 1",
                     o_nCommitted, o_empty, o_full, o_nDropped);
        end
        drive(1, 8'h42, 1, 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd1 || o_data !== 8'h42) begin
            n_bad++;
            $display("FAIL flush_after got ncom=%0d data=%h want 1 42", o_nCommitted, o_data);
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) drive(1, 8'h60 + 8'(i), (i == 2), 0, 0);
        drive(1, 8'h70, 0, 1, 0);
        drive(1, 8'h71, 0, 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd2 || o_data !== 8'h61) begin
            n_bad++;
            $display("FAIL areset_pre got ncom=%0d data=%h want 2 61", o_nCommitted, o_data);
        end
        #2;
        i_rst = 1;
        #1;
        n_cmp++;
        if (o_empty !== 1'b1 || o_full !== 1'b0 || o_nCommitted !== 6'd0 || o_nDropped !== 8'd0) begin
            n_bad++;
            $display("FAIL areset_immediate got empty=%b full=%b ncom=%0d ndrop=%0d want 1 0 0 0",
                     o_empty, o_full, o_nCommitted, o_nDropped);
        end
        @(posedge i_clk); #1;
        i_rst = 0;
        drive(1, 8'h55, 1, 0, 0);
        n_cmp++;
        if (o_nCommitted !== 6'd1 || o_data !== 8'h55) begin
            n_bad++;
            $display("FAIL areset_after got ncom=%0d data=%h want 1 55", o_nCommitted, o_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_uncommitted();
        test_overflow();
        test_wrap();
        test_cg();
        test_flush_simul();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
